sha1_sched: RTL and testbench

SHA1_SCHED -- requirements
Module: sha1_sched

---
 rtl/sha1_sched.sv | 122 ++++++++++++
 tb/tb_sha1_sched.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sha1_sched.sv
// Round-robin scheduler that time-shares one SHA-1 round pipeline among NREQ
// requesters, one 80-cycle block at a time, fetching 16 message words per block.
module sha1_sched #(
    parameter int NREQ = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   din,
    output logic [NREQ-1:0]      gnt,
    output logic [3:0]           rd_idx,
    output logic                 load7,
    output logic                 phase_advance7,
    output logic [31:0]          D,
    output logic [NREQ-1:0]      done,
    output logic                 busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t          state, state_nxt;
    logic [6:0]      cnt, cnt_nxt;
    logic [NREQ-1:0] gnt_nxt;
    // ptr is the first index searched at the next arbitration point
    logic [IW-1:0]   ptr, ptr_nxt;

    logic [NREQ-1:0] win_oh;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   ptr_adv;
    logic            found;
    logic            last_cycle;
    logic [31:0]     owner_word;

    always_comb begin : arb
        int idx;
        idx     = 0;
        win_oh  = '0;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found       = 1'b1;
                win_oh[idx] = 1'b1;
                win_idx     = IW'(idx);
            end
        end
    end

    assign ptr_adv = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

    always_comb begin
        owner_word = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (gnt[k]) owner_word = din[32*k +: 32];
        end
    end

    assign last_cycle     = (state == RUN) && (cnt == 7'd79);
    assign busy           = (state == RUN);
    assign load7          = (state == RUN) && (cnt < 7'd16);
    assign phase_advance7 = (state == RUN) && ((cnt % 7'd20) == 7'd19);
    assign rd_idx         = cnt[3:0];
    assign done           = last_cycle ? gnt : '0;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    gnt_nxt   = win_oh;
                    ptr_nxt   = ptr_adv;
                end
            end
            RUN: begin
                if (cnt == 7'd79) begin
                    // Owner is last in search order, so it only repeats when alone
                    if (found) begin
                        cnt_nxt = '0;
                        gnt_nxt = win_oh;
                        ptr_nxt = ptr_adv;
                    end else begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                        gnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 7'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            gnt   <= '0;
            ptr   <= '0;
            D     <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
            D     <= load7 ? owner_word : 32'h0;
        end
    end

endmodule

// File: tb/tb_sha1_sched.sv
// Directed bench for sha1_sched: per-cycle block checks, with expected
// message words queued at block start and consumed as D is observed.
module tb_sha1_sched;

    localparam int NREQ = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req;
    logic [32*NREQ-1:0]  din;
    logic [NREQ-1:0]     gnt;
    logic [3:0]          rd_idx;
    logic                load7;
    logic                phase_advance7;
    logic [31:0]         D;
    logic [NREQ-1:0]     done;
    logic                busy;

    int checks   = 0;
    int failures = 0;
    logic [31:0] sb[$];

    sha1_sched #(.NREQ(NREQ)) dut (
        .clk(clk), .rst(rst), .req(req), .din(din), .gnt(gnt),
        .rd_idx(rd_idx), .load7(load7), .phase_advance7(phase_advance7),
        .D(D), .done(done), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] wfun(input int k, input logic [3:0] i);
        logic [31:0] w;
        if (k == 0) begin
            case (i)
                4'd0:    w = 32'h54686973;
                4'd1:    w = 32'h20697320;
                4'd15:   w = 32'h00000080;
                default: w = 32'h61207400 | 32'(i);
            endcase
        end else begin
            w = 32'hA0000005 | (32'(k) << 24) | (32'(i) << 4);
        end
        return w;
    endfunction

    always_comb begin
        din = '0;
        for (int k = 0; k < NREQ; k++) din[32*k +: 32] = wfun(k, rd_idx);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'h0);
        chk({tag, "_load7"}, 32'(load7), 32'h0);
        chk({tag, "_phase"}, 32'(phase_advance7), 32'h0);
        chk({tag, "_done"},  32'(done), 32'h0);
        chk({tag, "_busy"},  32'(busy), 32'h0);
        chk({tag, "_D"},     D, 32'h0);
    endtask

    // Checks block cycles 0..len-1 of a block owned by 'owner', ticking after each.
    // req is set to chg_v after cycle chg_c and to end_v during cycle 79.
    task automatic run_block(input int owner, input int len, input int chg_c,
                             input logic [NREQ-1:0] chg_v, input logic [NREQ-1:0] end_v);
        logic [31:0] exp_d;
        for (int i = 0; i < 16; i++) sb.push_back(wfun(owner, 4'(i)));
        for (int c = 0; c < len; c++) begin
            chk("blk_gnt",   32'(gnt), 32'(1) << owner);
            chk("blk_busy",  32'(busy), 32'h1);
            chk("blk_load7", 32'(load7), 32'(c < 16));
            if (c < 16) chk("blk_rd_idx", 32'(rd_idx), 32'(c));
            chk("blk_phase", 32'(phase_advance7), 32'((c % 20) == 19));
            chk("blk_done",  32'(done), (c == 79) ? (32'(1) << owner) : 32'h0);
            exp_d = 32'h0;
            if (c >= 1 && c <= 16) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $error("FAIL sb_empty observed=%0d expected=%0d", 0, 1);
                end else begin
                    exp_d = sb.pop_front();
                end
            end
            chk("blk_D", D, exp_d);
            if (c == chg_c) req = chg_v;
            if (c == 79) req = end_v;
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        tick();
        tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("idle");

        // Single requester 0 block, then idle
        req = 4'b0001;
        tick();
        run_block(0, 80, -1, '0, 4'b0000);
        chk_idle("after_single");
        tick();
        chk_idle("after_single2");

        // Reset restores requester 0 priority; all four requesting rotate 0,1,2,3,0
        rst = 1'b1;
        tick();
        chk_idle("reset2");
        rst = 1'b0;
        req = 4'b1111;
        tick();
        run_block(0, 80, -1, '0, 4'b1111);
        run_block(1, 80, -1, '0, 4'b1111);
        run_block(2, 80, -1, '0, 4'b1111);
        run_block(3, 80, -1, '0, 4'b1111);
        run_block(0, 80, -1, '0, 4'b0000);
        chk_idle("after_rr");

        // Lone requester 2 wins back-to-back blocks
        req = 4'b0100;
        tick();
        run_block(2, 80, -1, '0, 4'b0100);
        run_block(2, 80, -1, '0, 4'b0000);
        chk_idle("after_lone");

        // Requester 1 arrives mid-block of owner 3; switch only at block end
        req = 4'b1000;
        tick();
        run_block(3, 80, 40, 4'b1010, 4'b0010);
        run_block(1, 80, -1, '0, 4'b0000);
        chk_idle("after_late");

        // Owner drops req at cycle 10; block still completes with done
        req = 4'b0001;
        tick();
        run_block(0, 80, 10, 4'b0000, 4'b0000);
        chk_idle("after_drop");

        // Reset at block cycle 30 aborts the block, then requester 0 wins
        req = 4'b0010;
        tick();
        run_block(1, 30, -1, '0, 4'b0010);
        chk("pre_rst_gnt", 32'(gnt), 32'h2);
        chk("pre_rst_done", 32'(done), 32'h0);
        rst = 1'b1;
        req = 4'b0011;
        tick();
        chk_idle("abort");
        rst = 1'b0;
        tick();
        run_block(0, 80, -1, '0, 4'b0000);
        chk_idle("final");
        chk("sb_drained", 32'(sb.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
